// File: rtl/result_demux2.sv
// Registered 1-to-2 steering stage for signed field-element results.
// One valid/ready source fans out to channel 0, channel 1, both, or a discard sink.
module result_demux2 #(
  parameter int WIDTH = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic        [1:0]       in_sel,
  output logic                    out0_valid,
  input  logic                    out0_ready,
  output logic signed [WIDTH-1:0] out0_data,
  output logic                    out1_valid,
  input  logic                    out1_ready,
  output logic signed [WIDTH-1:0] out1_data,
  output logic                    err,
  input  logic                    err_clr,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ROUTE_CH0  = 2'd0,
    ROUTE_CH1  = 2'd1,
    ROUTE_BOTH = 2'd2,
    ROUTE_DROP = 2'd3
  } route_e;

  route_e                  route;
  logic                    xfer;
  logic [1:0]              avail;
  logic [1:0]              load;
  logic [1:0]              sink_ready;
  logic [1:0]              valid_q;
  logic signed [WIDTH-1:0] data_q [2];

  assign route      = route_e'(in_sel);
  assign sink_ready = {out1_ready, out0_ready};

  // A slot is free when empty or when its word leaves this cycle.
  assign avail = ~valid_q | sink_ready;

  always_comb begin
    // NOTE: default assignment first so every path drives in_ready and no latch is inferred.
    in_ready = 1'b0;
    case (route)
      ROUTE_CH0:  in_ready = avail[0];
      ROUTE_CH1:  in_ready = avail[1];
      ROUTE_BOTH: in_ready = avail[0] && avail[1];
      ROUTE_DROP: in_ready = 1'b1;
      default:    in_ready = 1'b0;
    endcase
  end

  assign xfer    = in_valid && in_ready;
  assign load[0] = xfer && ((route == ROUTE_CH0) || (route == ROUTE_BOTH));
  assign load[1] = xfer && ((route == ROUTE_CH1) || (route == ROUTE_BOTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      // NOTE: the data registers are reset too, because the outputs must read zero after reset.
      for (int k = 0; k < 2; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        // NOTE: non-blocking updates keep every slot sampling pre-edge values.
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= in_data;
        end else if (sink_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Set wins over clear so a discard in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (xfer && (route == ROUTE_DROP)) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign busy       = valid_q[0] || valid_q[1];

endmodule

// File: tb/tb_result_demux2.sv
// Scoreboard bench for result_demux2: the driver queues expected words per channel,
// and a monitor pops and compares them whenever a channel hands a word over.
module tb_result_demux2;

  localparam int W = 256;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic        [1:0]   in_sel;
  logic                out0_valid;
  logic                out0_ready;
  logic signed [W-1:0] out0_data;
  logic                out1_valid;
  logic                out1_ready;
  logic signed [W-1:0] out1_data;
  logic                err;
  logic                err_clr;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  result_demux2 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .err        (err),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [W-1:0] data, input logic [1:0] sel);
    in_valid = 1'b1;
    in_data  = data;
    in_sel   = sel;
  endtask

  // Holds the current word until accepted, records what each channel should emit,
  // then withdraws in_valid just after the accepting edge.
  task automatic wait_xfer(input int budget, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        case (in_sel)
          2'd0: q0.push_back(in_data);
          2'd1: q1.push_back(in_data);
          2'd2: begin q0.push_back(in_data); q1.push_back(in_data); end
          default: ;
        endcase
      end else begin
        stalls++;
      end
    end
    check("xfer_within_budget", W'(done), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] data, input logic [1:0] sel);
    int s;
    drive(data, sel);
    wait_xfer(20, s);
  endtask

  // Monitor: compares every handed-over word and checks output stability under backpressure.
  logic         stall0_q, stall1_q;
  logic [W-1:0] hold0_q, hold1_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall0_q = 1'b0;
      stall1_q = 1'b0;
    end else begin
      if (stall0_q) begin
        check("out0_hold_valid", W'(out0_valid), W'(1));
        check("out0_hold_data", out0_data, hold0_q);
      end
      if (stall1_q) begin
        check("out1_hold_valid", W'(out1_valid), W'(1));
        check("out1_hold_data", out1_data, hold1_q);
      end
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("out0_unexpected_word", W'(out0_valid), W'(0));
        else                check("out0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("out1_unexpected_word", W'(out1_valid), W'(0));
        else                check("out1_data", out1_data, q1.pop_front());
      end
      stall0_q = out0_valid && !out0_ready;
      stall1_q = out1_valid && !out1_ready;
      hold0_q  = out0_data;
      hold1_q  = out1_data;
    end
  end

  // Source contract: a stalled word stays put until accepted.
  logic         src_stall_q;
  logic [W-1:0] src_data_q;
  logic [1:0]   src_sel_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      src_stall_q = 1'b0;
    end else begin
      if (src_stall_q)
        assert (in_valid && in_data == src_data_q && in_sel == src_sel_q)
          else $error("source changed a stalled word");
      src_stall_q = in_valid && !in_ready;
      src_data_q  = in_data;
      src_sel_q   = in_sel;
    end
  end

  initial begin
    logic [W-1:0] minus1;
    logic [W-1:0] abcd;
    int           s;
    int           total_stalls;
    minus1     = '1;
    abcd       = W'(16'hABCD);
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = 2'd0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    err_clr    = 1'b0;

    #1;
    check("rst_out0_valid", W'(out0_valid), W'(0));
    check("rst_out1_valid", W'(out1_valid), W'(0));
    check("rst_out0_data", out0_data, W'(0));
    check("rst_out1_data", out1_data, W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_busy", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Channel 0 route with one-cycle latency.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(W'(1), 2'd0);
    check("ch0_pre_valid", W'(out0_valid), W'(0));
    wait_xfer(20, s);
    check("ch0_valid", W'(out0_valid), W'(1));
    check("ch0_data", out0_data, W'(1));
    check("ch0_out1_idle", W'(out1_valid), W'(0));
    check("ch0_busy", W'(busy), W'(1));

    // Backpressure on channel 1.
    out1_ready = 1'b0;
    send(minus1, 2'd1);
    check("bp_first_data", out1_data, minus1);
    drive(W'(5), 2'd1);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_hold_data", out1_data, minus1);
    end
    @(posedge clk);
    #1;
    out1_ready = 1'b1;
    wait_xfer(20, s);
    check("bp_second_valid", W'(out1_valid), W'(1));
    check("bp_second_data", out1_data, W'(5));

    // Broadcast held off by a full channel 1 must not load channel 0.
    @(posedge clk);
    #1;
    out1_ready = 1'b0;
    send(W'(8'h77), 2'd1);
    drive(abcd, 2'd2);
    repeat (3) begin
      @(negedge clk);
      check("bc_in_ready", W'(in_ready), W'(0));
      check("bc_out0_unloaded", W'(out0_valid), W'(0));
    end
    @(posedge clk);
    #1;
    out1_ready = 1'b1;
    wait_xfer(20, s);
    check("bc_out0_valid", W'(out0_valid), W'(1));
    check("bc_out1_valid", W'(out1_valid), W'(1));
    check("bc_out0_data", out0_data, abcd);
    check("bc_out1_data", out1_data, abcd);

    // Streaming 64 words back to back on channel 0.
    total_stalls = 0;
    for (int i = 0; i < 64; i++) begin
      drive(W'(i), 2'd0);
      wait_xfer(4, s);
      total_stalls += s;
    end
    check("stream_stalls", W'(total_stalls), W'(0));
    check("stream_last", out0_data, W'(63));
    repeat (2) @(posedge clk);
    #1;

    // Discard and sticky error.
    drive(W'(7), 2'd3);
    check("drop_in_ready", W'(in_ready), W'(1));
    wait_xfer(20, s);
    check("drop_err", W'(err), W'(1));
    check("drop_out0_idle", W'(out0_valid), W'(0));
    check("drop_out1_idle", W'(out1_valid), W'(0));
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_cleared", W'(err), W'(0));
    err_clr = 1'b1;
    drive(W'(8), 2'd3);
    wait_xfer(20, s);
    err_clr = 1'b0;
    check("err_set_wins", W'(err), W'(1));

    // Asynchronous reset with channel 0 full and a broadcast stalled.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(W'(8'h11), 2'd0);
    send(W'(8'h22), 2'd1);
    drive(W'(8'h33), 2'd2);
    @(negedge clk);
    check("pre_rst_out0_valid", W'(out0_valid), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out0_valid", W'(out0_valid), W'(0));
    check("arst_out1_valid", W'(out1_valid), W'(0));
    check("arst_out0_data", out0_data, W'(0));
    check("arst_out1_data", out1_data, W'(0));
    check("arst_err", W'(err), W'(0));
    in_valid = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;

    // Sign bit survives a broadcast after reset.
    send(minus1 ^ W'(1), 2'd2);
    check("post_rst_out0", out0_data, minus1 ^ W'(1));
    check("post_rst_out1", out1_data, minus1 ^ W'(1));

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", W'(q0.size()), W'(0));
    check("q1_drained", W'(q1.size()), W'(0));
    check("final_busy", W'(busy), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_demux2.md
Name: result_demux2

Overview:
- Registered 1-to-2 steering stage for 256-bit signed field-element results in the elliptic curve datapath.
- Takes one result stream, driven by the arithmetic units, and delivers each word to operand channel 0, operand channel 1, or both (broadcast).
- Full valid/ready handshaking on all channels, with a single-entry output buffer per channel.
- Counterpart to the 2:1 operand-select mux: that mux merges two sources; this block fans one source out to two sinks.

Parameters:
- WIDTH, 256, data word width in bits; data is treated as signed and passed through unmodified.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  WIDTH  signed input word.
- in_sel  in  2  route: 0=ch0, 1=ch1, 2=both, 3=discard.
- out0_valid  out  1  channel 0 word present.
- out0_ready  in  1  channel 0 consumer accepts.
- out0_data  out  WIDTH  channel 0 signed word.
- out1_valid  out  1  channel 1 word present.
- out1_ready  in  1  channel 1 consumer accepts.
- out1_data  out  WIDTH  channel 1 signed word.
- err  out  1  sticky: a discard (sel=3) transfer occurred.
- err_clr  in  1  synchronous clear of err.
- busy  out  1  out0_valid OR out1_valid.

Behaviour:
- Reset: asynchronous on rst_n low. out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, err=0. Reset mid-transfer drops any buffered words; there is no recovery of lost data.
- Slot availability: availK = !outK_valid || outK_ready (drain and refill allowed in the same cycle).
- in_ready is combinational from in_sel and the avail signals:
  - sel0 -> avail0
  - sel1 -> avail1
  - sel2 -> avail0 && avail1
  - sel3 -> 1
- Transfer: occurs when in_valid && in_ready.
- Source contract: in_data and in_sel are held stable while in_valid && !in_ready; in_valid is not withdrawn before the transfer. The bench checks this as an assertion on the source.
- Load: on a transfer with sel routing to channel K, outK_data <= in_data and outK_valid <= 1 at the next edge. Latency is 1 cycle from input transfer to outK_valid.
- Drain: if outK_valid && outK_ready and there is no load to K in the same cycle, outK_valid <= 0 next edge. outK_data holds its last value.
- Simultaneous drain and load on K: the new word replaces the old one; valid stays 1. Sustained throughput is 1 word/cycle per channel.
- Broadcast (sel2) is atomic: both channels load in the same cycle or neither does. There are no partial deliveries.
- Output stability: while outK_valid && !outK_ready, outK_data is stable and outK_valid remains 1.
- Discard (sel3): word accepted immediately, no channel is touched, err <= 1 next edge.
- err_clr: err <= 0 unless a sel3 transfer occurs in the same cycle; set wins.
- Data: no arithmetic, sign or width change; bit-exact pass-through of all WIDTH bits, including the MSB sign bit.
- No combinational path from in_data to out data. The only combinational paths are outK_ready -> in_ready and in_sel -> in_ready.

Test Plan:
- Reset then ch0 route: release rst_n, drive in_data=256'h1 with sel=0 for one cycle, out0_ready=1 -> out0_valid=1 with out0_data=1 exactly one cycle later, out1_valid stays 0.
- Backpressure: out1_ready=0, send 256'hFFFF...FF (i.e. -1) with sel=1, then 256'h5 with sel=1 -> second word stalls with in_ready=0. out1_data holds -1 until out1_ready=1, then 5 appears the next cycle; no loss, no duplication.
- Broadcast atomicity: out0_ready=1, out1_ready=0 with out1 full, send 256'hABCD with sel=2 -> in_ready=0 and out0 is not loaded. After out1_ready=1, both channels present 256'hABCD on the same cycle.
- Streaming: 64 consecutive sel=0 words 0..63 with out0_ready=1 throughout -> in_ready constantly 1; out0 shows 0..63 in order, one per cycle.
- Discard and error: sel=3 with data 7 -> in_ready=1, no output valid, err=1. err_clr pulse -> err=0 next cycle. err_clr coincident with a sel=3 transfer -> err remains 1.
- Async reset mid-operation: assert rst_n low between edges while out0_valid=1 and a broadcast is stalled -> out0_valid, out1_valid, out0_data, out1_data and err all go to 0 immediately, without waiting for a clock edge.
